req_encoder16x4: RTL

- Sequential 16-to-4 request encoder: the inverse of the existing 4x16 decoder path.
- Accumulates up to 16 request lines d0..d15 into a pending register and offers one pending request at a time as a 4-bit index with a valid/ready handshake.
- Clears each request when the consumer accepts it.
- Sits in front of any decoder4x16-based function or unit that consumes one minterm/index per cycle.

---
 rtl/req_encoder_pkg.sv | 27 ++
 rtl/req_encoder16x4_prio_enc16.sv | 40 ++++
 rtl/req_encoder16x4.sv | 124 ++++++++++++
 3 files changed

// File: rtl/req_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : req_encoder_pkg
//  Brief    : Shared constants, FSM state encoding and one-hot helper for the
//             16-to-4 sequential request encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package req_encoder_pkg;

    localparam int NREQ = 16;
    localparam int IDXW = 4;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    // Expand a 4-bit index into its 16-bit one-hot mask
    function automatic logic [NREQ-1:0] onehot16(input logic [IDXW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_encoder16x4_prio_enc16.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc16
//  Brief    : Combinational 16-bit priority encoder. Returns the index of the
//             first set bit found searching upward from 'start' and wrapping
//             15->0; returns 0 when no bit is set.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_enc16
    import req_encoder_pkg::*;
(
    input  logic [NREQ-1:0] vec,
    input  logic [IDXW-1:0] start,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [NREQ-1:0] w_rot;
    logic [IDXW-1:0] w_off;

    // Rotate so 'start' lands at bit 0, then pick the lowest set bit
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = vec[IDXW'(i + int'(start))];
        end
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDXW'(i);
            end
        end
    end

    assign any = |vec;
    // Offset is relative to 'start'; 4-bit addition wraps naturally
    assign idx = any ? (w_off + start) : '0;

endmodule
`default_nettype wire

// File: rtl/req_encoder16x4.sv
`default_nettype none
// ============================================================================
//  Module   : req_encoder16x4
//  Brief    : Sequential 16-to-4 request encoder. Captures request lines into
//             a pending register and offers one pending index at a time over
//             a valid/ready handshake, clearing each request on acceptance.
//             Optional macro REQ_ENCODER_ROUND_ROBIN_EN switches from fixed
//             lowest-index priority to round-robin starting after the last
//             accepted index.
//  Revision : 1.0 - initial release
// ============================================================================
module req_encoder16x4
    import req_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] d,
    input  logic            ready,
    output logic            valid,
    output logic [IDXW-1:0] idx,
    output logic [NREQ-1:0] pending_o,
    output logic            dup
);

    localparam logic [IDXW-1:0] c_idx_one = {{(IDXW-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_pending;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] w_idx_nxt;
    logic            r_dup;

    logic            w_acc;
    logic [NREQ-1:0] w_clr;
    logic [NREQ-1:0] w_set;
    logic [NREQ-1:0] w_rem;
    logic [NREQ-1:0] w_pending_nxt;
    logic [IDXW-1:0] w_start;
    logic [IDXW-1:0] w_enc;
    logic            w_any;

    assign w_acc         = (r_state == S_OFFER) && ready;
    assign w_clr         = w_acc ? onehot16(r_idx) : '0;
    assign w_set         = en ? d : '0;
    // Outside an accept w_clr is zero, so w_rem equals the pending register;
    // new arrivals are deliberately excluded from the next search.
    assign w_rem         = r_pending & ~w_clr;
    assign w_pending_nxt = w_rem | w_set;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    logic [IDXW-1:0] r_last;

    // Remember the most recently accepted index to rotate the search origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= {IDXW{1'b1}};
        end else if (w_acc) begin
            r_last <= r_idx;
        end
    end

    // On an accept the origin moves past the index just granted
    assign w_start = w_acc ? (r_idx + c_idx_one) : (r_last + c_idx_one);
`else
    assign w_start = '0;
`endif

    prio_enc16 u_prio_enc16 (
        .vec   (w_rem),
        .start (w_start),
        .idx   (w_enc),
        .any   (w_any)
    );

    // Next-state and next-index selection; idx is frozen while an offer waits
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_OFFER;
                    w_idx_nxt   = w_enc;
                end
            end
            S_OFFER: begin
                if (w_acc) begin
                    if (w_any) begin
                        w_idx_nxt = w_enc;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, index, pending set and merged-request pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_pending <= '0;
            r_dup     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_dup     <= |(w_set & r_pending & ~w_clr);
        end
    end

    assign valid     = (r_state == S_OFFER);
    assign idx       = r_idx;
    assign pending_o = r_pending;
    assign dup       = r_dup;

endmodule
`default_nettype wire
